// File: rtl/csr_rmw_ctrl.sv
// CSR read-modify-write sequencer: reads the target CSR, applies the RW/RS/RC update,
// issues at most one write strobe and returns the old value (or an illegal flag).
module csr_rmw_ctrl #(
  parameter int XLEN = 64,
  parameter int AW   = 12
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [XLEN-1:0] req_rs1_data_i,
  input  logic [4:0]      req_rs1_idx_i,
  output logic [AW-1:0]   csr_addr_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  output logic            csr_wr_en_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_illegal_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic            ready_reg;
  logic [2:0]      op_reg;
  logic [AW-1:0]   addr_reg;
  logic [XLEN-1:0] rs1_data_reg;
  logic [4:0]      rs1_idx_reg;
  logic [XLEN-1:0] old_reg;
  logic [XLEN-1:0] wdata_reg;
  logic            illegal_reg;

  logic            accept;
  logic            req_legal;
  logic            write_intent;
  logic            read_only;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] new_val;

  assign accept       = req_valid_i && ready_reg && (state_reg == IDLE);
  assign req_legal    = (req_op_i[1:0] != 2'b00);
  // op[2] selects the immediate forms, where the rs1 index doubles as uimm.
  assign src          = op_reg[2] ? {{(XLEN-5){1'b0}}, rs1_idx_reg} : rs1_data_reg;
  assign write_intent = (op_reg[1:0] == 2'b01) || (rs1_idx_reg != 5'd0);
  assign read_only    = (addr_reg[AW-1 -: 2] == 2'b11);

  always_comb begin
    case (op_reg[1:0])
      2'b10:   new_val = csr_rdata_i | src;
      2'b11:   new_val = csr_rdata_i & ~src;
      default: new_val = src;
    endcase
  end

  // Ready is registered so it stays low through reset and rises on the first edge after.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = req_legal ? READ : RESP;
      READ:    state_next = (write_intent && !read_only) ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    csr_wr_en_o = (state_reg == WRITE);
    rsp_valid_o = (state_reg == RESP);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_reg       <= '0;
      addr_reg     <= '0;
      rs1_data_reg <= '0;
      rs1_idx_reg  <= '0;
      old_reg      <= '0;
      wdata_reg    <= '0;
      illegal_reg  <= 1'b0;
    end else if (accept) begin
      op_reg       <= req_op_i;
      addr_reg     <= req_addr_i;
      rs1_data_reg <= req_rs1_data_i;
      rs1_idx_reg  <= req_rs1_idx_i;
      illegal_reg  <= !req_legal;
      old_reg      <= '0;
    end else if (state_reg == READ) begin
      wdata_reg <= new_val;
      // A write to a read-only CSR faults and must not leak the old value.
      if (write_intent && read_only) begin
        illegal_reg <= 1'b1;
        old_reg     <= '0;
      end else begin
        old_reg <= csr_rdata_i;
      end
    end
  end

  assign req_ready_o   = ready_reg;
  assign csr_addr_o    = addr_reg;
  assign csr_wdata_o   = wdata_reg;
  assign rsp_rdata_o   = old_reg;
  assign rsp_illegal_o = illegal_reg;

endmodule

// File: tb/tb_csr_rmw_ctrl.sv
// Bench for csr_rmw_ctrl: table of CSR instructions against a behavioural CSR file,
// with a scoreboard queue and hand-written reset sequences.
module tb_csr_rmw_ctrl;
  localparam int XLEN = 64;
  localparam int AW   = 12;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      req_op_i;
  logic [AW-1:0]   req_addr_i;
  logic [XLEN-1:0] req_rs1_data_i;
  logic [4:0]      req_rs1_idx_i;
  logic [AW-1:0]   csr_addr_o;
  logic [XLEN-1:0] csr_rdata_i;
  logic            csr_wr_en_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [XLEN-1:0] rsp_rdata_o;
  logic            rsp_illegal_o;

  csr_rmw_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op_i),
    .req_addr_i     (req_addr_i),
    .req_rs1_data_i (req_rs1_data_i),
    .req_rs1_idx_i  (req_rs1_idx_i),
    .csr_addr_o     (csr_addr_o),
    .csr_rdata_i    (csr_rdata_i),
    .csr_wr_en_o    (csr_wr_en_o),
    .csr_wdata_o    (csr_wdata_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_illegal_o  (rsp_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  logic [XLEN-1:0] csr_mem [0:(1<<AW)-1];
  assign csr_rdata_i = csr_mem[csr_addr_o];

  typedef struct {
    logic [2:0]      op;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] rs1_data;
    logic [4:0]      idx;
    logic [XLEN-1:0] init;
    logic [XLEN-1:0] rdata;
    logic            ill;
    logic            wr;
    logic [XLEN-1:0] wdata;
    int              lat;
    int              stall;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] rdata;
    logic            ill;
    logic            wr;
    logic [XLEN-1:0] wdata;
    int              lat;
    logic [XLEN-1:0] final_val;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    exp_t            e;
    int              cyc;
    int              wr_cnt;
    int              wr_cyc;
    logic [XLEN-1:0] wdata_seen;
    logic            got;
    logic [XLEN-1:0] rd0;
    logic            ill0;
    csr_mem[v.addr] = v.init;
    rsp_ready_i = (v.stall == 0);
    @(negedge clk_i);
    chk("req_ready_idle", 64'(req_ready_o), 64'(1));
    req_valid_i    = 1'b1;
    req_op_i       = v.op;
    req_addr_i     = v.addr;
    req_rs1_data_i = v.rs1_data;
    req_rs1_idx_i  = v.idx;
    e.rdata     = v.rdata;
    e.ill       = v.ill;
    e.wr        = v.wr;
    e.wdata     = v.wdata;
    e.lat       = v.lat;
    e.final_val = v.wr ? v.wdata : v.init;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    req_valid_i    = 1'b0;
    req_op_i       = 3'($urandom);
    req_addr_i     = AW'($urandom);
    req_rs1_data_i = {$urandom, $urandom};
    req_rs1_idx_i  = 5'($urandom);
    cyc = 0; wr_cnt = 0; wr_cyc = 0; wdata_seen = '0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
      if (csr_wr_en_o) begin
        wr_cnt++;
        wr_cyc = cyc;
        wdata_seen = csr_wdata_o;
        chk("wr_addr", 64'(csr_addr_o), 64'(v.addr));
        csr_mem[csr_addr_o] = csr_wdata_o;
      end
      if (rsp_valid_o) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout txn %0d: got no response, required one within 20 cycles", id);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      rsp_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      return;
    end
    e = sb_q.pop_front();
    chk("latency", 64'(cyc), 64'(e.lat));
    chk("rsp_rdata", rsp_rdata_o, e.rdata);
    chk("rsp_illegal", 64'(rsp_illegal_o), 64'(e.ill));
    chk("rsp_req_ready", 64'(req_ready_o), 64'(0));
    rd0  = rsp_rdata_o;
    ill0 = rsp_illegal_o;
    for (int k = 0; k < v.stall; k++) begin
      @(negedge clk_i);
      if (csr_wr_en_o) wr_cnt++;
      chk("stall_valid", 64'(rsp_valid_o), 64'(1));
      chk("stall_rdata", rsp_rdata_o, rd0);
      chk("stall_illegal", 64'(rsp_illegal_o), 64'(ill0));
      chk("stall_req_ready", 64'(req_ready_o), 64'(0));
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    if (csr_wr_en_o) wr_cnt++;
    chk("done_valid", 64'(rsp_valid_o), 64'(0));
    chk("done_req_ready", 64'(req_ready_o), 64'(1));
    chk("wr_count", 64'(wr_cnt), e.wr ? 64'(1) : 64'(0));
    if (e.wr) begin
      chk("wr_cycle", 64'(wr_cyc), 64'(2));
      chk("wdata", wdata_seen, e.wdata);
    end
    chk("csr_final", csr_mem[v.addr], e.final_val);
    $display("txn %0d: op=%b addr=%h rdata=%h illegal=%0d writes=%0d latency=%0d",
             id, v.op, v.addr, rd0, ill0, wr_cnt, cyc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready_o), 64'(0));
    chk({tag, "_wr_en"}, 64'(csr_wr_en_o), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'(0));
    chk({tag, "_rsp_illegal"}, 64'(rsp_illegal_o), 64'(0));
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 64'(0));
    chk({tag, "_wdata"}, csr_wdata_o, 64'(0));
    chk({tag, "_addr"}, 64'(csr_addr_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'b001, 12'h300, 64'h5, 5'd5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 64'h5, 3, 0};
    vecs[1]  = '{3'b010, 12'h300, 64'hF0, 5'd3, 64'h0F, 64'h0F, 1'b0, 1'b1, 64'hFF, 3, 5};
    vecs[2]  = '{3'b111, 12'h300, 64'hDEAD, 5'd0, 64'hAA, 64'hAA, 1'b0, 1'b0, 64'h0, 2, 0};
    vecs[3]  = '{3'b001, 12'hC00, 64'h1, 5'd1, 64'h77, 64'h0, 1'b1, 1'b0, 64'h0, 2, 0};
    vecs[4]  = '{3'b100, 12'h300, 64'h3, 5'd3, 64'h55, 64'h0, 1'b1, 1'b0, 64'h0, 1, 0};
    vecs[5]  = '{3'b011, 12'h341, 64'hFF00, 5'd4, 64'hFFFF, 64'hFFFF, 1'b0, 1'b1, 64'h00FF, 3, 0};
    vecs[6]  = '{3'b101, 12'h340, 64'hFFFF, 5'd0, 64'h1234, 64'h1234, 1'b0, 1'b1, 64'h0, 3, 0};
    vecs[7]  = '{3'b010, 12'h342, 64'hFF, 5'd0, 64'h3, 64'h3, 1'b0, 1'b0, 64'h0, 2, 0};
    vecs[8]  = '{3'b010, 12'hC01, 64'h1, 5'd0, 64'hC0FFEE, 64'hC0FFEE, 1'b0, 1'b0, 64'h0, 2, 0};
    vecs[9]  = '{3'b111, 12'hF11, 64'h0, 5'd2, 64'h1F, 64'h0, 1'b1, 1'b0, 64'h0, 2, 2};
    vecs[10] = '{3'b000, 12'h300, 64'h1, 5'd1, 64'h9, 64'h0, 1'b1, 1'b0, 64'h0, 1, 0};
    vecs[11] = '{3'b110, 12'h305, 64'hFFFF_FFFF, 5'h1F, 64'h100, 64'h100, 1'b0, 1'b1, 64'h11F, 3, 0};

    rst_n_i        = 1'b1;
    req_valid_i    = 1'b0;
    req_op_i       = '0;
    req_addr_i     = '0;
    req_rs1_data_i = '0;
    req_rs1_idx_i  = '0;
    rsp_ready_i    = 1'b0;
    #2 rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_reset_outputs("por");
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("por_release_ready", 64'(req_ready_o), 64'(1));
    $display("txn por: reset released, req_ready=%0d", req_ready_o);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset while a write-bound request sits in READ.
    csr_mem[12'h300] = 64'h1234;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    req_valid_i    = 1'b1;
    req_op_i       = 3'b001;
    req_addr_i     = 12'h300;
    req_rs1_data_i = 64'h99;
    req_rs1_idx_i  = 5'd1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    #1 rst_n_i = 1'b0;
    #1 chk_reset_outputs("midrst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("midrst_hold_wr_en", 64'(csr_wr_en_o), 64'(0));
      chk("midrst_hold_valid", 64'(rsp_valid_o), 64'(0));
    end
    rst_n_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("midrst_after_wr_en", 64'(csr_wr_en_o), 64'(0));
      chk("midrst_after_valid", 64'(rsp_valid_o), 64'(0));
      chk("midrst_after_ready", 64'(req_ready_o), 64'(1));
    end
    chk("midrst_csr_untouched", csr_mem[12'h300], 64'h1234);
    $display("txn midrst: reset during READ, csr=%h", csr_mem[12'h300]);

    run_vec(12, vecs[0]);
    run_vec(13, vecs[5]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
